fft_power: RTL and testbench

Downstream consumer of the 1024-point FFT stage. Accepts the FFT's complex output bins over AXI-Stream and computes the squared magnitude of each bin. Forwards only the non-redundant half-spectrum (bins 0..511) as scaled, saturated power values, each tagged with its bin index. An optional per-frame peak tracker reports the strongest bin once per frame.

---
 rtl/fft_pkg.sv | 15 +
 rtl/cmag_sq.sv | 63 ++++++
 rtl/fft_power.sv | 182 ++++++++++++++++++
 tb/tb_fft_power.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT post-processing blocks.
//   FFT_N / FFT_HALF : transform length and size of the non-redundant half-spectrum.
//   fft_bin_t        : full-frame bin index (0..1023).
//   half_bin_t       : half-spectrum bin index (0..511).
//   IN_W_DEFAULT     : default width of one signed real/imag component.
package fft_pkg;

  localparam int unsigned FFT_N        = 1024;
  localparam int unsigned FFT_HALF     = 512;
  localparam int unsigned IN_W_DEFAULT = 24;

  typedef logic [9:0] fft_bin_t;
  typedef logic [8:0] half_bin_t;

endpackage

// File: rtl/cmag_sq.sv
// Registered squared-magnitude arithmetic for one complex sample per cycle.
// Stage registers hold re^2 and im^2 (plus valid/bin sideband); the sum of the
// two squares is presented combinationally so the caller can scale and
// saturate it into its own output register.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : stage load enable (pipeline advance)
//   valid_i/bin_i : sideband of the incoming sample
//   re_i, im_i    : signed components
//   valid_o/bin_o : sideband of the registered squares
//   sum_o         : re^2 + im^2, unsigned, one bit wider than a single square
module cmag_sq
  import fft_pkg::*;
#(
  parameter int unsigned IN_W = IN_W_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  half_bin_t              bin_i,
  input  logic signed [IN_W-1:0] re_i,
  input  logic signed [IN_W-1:0] im_i,
  output logic                   valid_o,
  output half_bin_t              bin_o,
  output logic [2*IN_W:0]        sum_o
);

  localparam int unsigned SqW = 2 * IN_W;

  logic signed [SqW-1:0] re_ext, im_ext;
  logic signed [SqW-1:0] re_sq_d, im_sq_d;
  logic [SqW-1:0]        re_sq_q, im_sq_q;
  logic                  valid_q;
  half_bin_t             bin_q;

  // Sign-extend before multiplying so the full-width product is exact; the most
  // negative input squares to 2^(2*IN_W-2), which still fits.
  always_comb begin
    re_ext  = {{IN_W{re_i[IN_W-1]}}, re_i};
    im_ext  = {{IN_W{im_i[IN_W-1]}}, im_i};
    re_sq_d = re_ext * re_ext;
    im_sq_d = im_ext * im_ext;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      valid_q <= 1'b0;
      bin_q   <= '0;
    end else if (en_i) begin
      re_sq_q <= $unsigned(re_sq_d);
      im_sq_q <= $unsigned(im_sq_d);
      valid_q <= valid_i;
      bin_q   <= bin_i;
    end
  end

  assign sum_o   = {1'b0, re_sq_q} + {1'b0, im_sq_q};
  assign valid_o = valid_q;
  assign bin_o   = bin_q;

endmodule

// File: rtl/fft_power.sv
// Power spectrum of a 1024-point FFT output stream. Each accepted bin is
// squared (re^2 + im^2), right-shifted by SHIFT and saturated to OUT_W bits.
// Only bins 0..511 are forwarded; bins 512..1023 are accepted and dropped.
// Frame position comes only from an input handshake counter (no tlast).
// Optional peak tracker enabled by defining FFT_POWER_PEAK_EN.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   din_valid_i/din_ready_o   : input stream handshake
//   din_data_i                : {imag, real}, each IN_W-bit two's complement
//   dout_valid_o/dout_ready_i : output stream handshake
//   dout_data_o               : scaled, saturated power
//   dout_bin_o                : bin index of dout_data_o
//   peak_valid_o              : one-cycle pulse after the bin 511 handshake
//   peak_bin_o/peak_pow_o     : strongest bin of the frame and its power
module fft_power
  import fft_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEFAULT,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned SHIFT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  input  logic [2*IN_W-1:0] din_data_i,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic [OUT_W-1:0]  dout_data_o,
  output half_bin_t         dout_bin_o
`ifdef FFT_POWER_PEAK_EN
  ,
  output logic              peak_valid_o,
  output half_bin_t         peak_bin_o,
  output logic [OUT_W-1:0]  peak_pow_o
`endif
);

  // Sum width must exceed OUT_W for the saturation test below to be meaningful.
  localparam int unsigned SumW    = 2 * IN_W + 1;
  localparam half_bin_t   LastBin = half_bin_t'(FFT_HALF - 1);

  fft_bin_t               cnt_q, cnt_d;
  logic                   advance, in_hs, out_hs;

  logic                   s1_valid_q;
  logic signed [IN_W-1:0] s1_re_q, s1_im_q;
  half_bin_t              s1_bin_q;

  logic                   s2_valid;
  half_bin_t              s2_bin;
  logic [SumW-1:0]        s2_sum;
  logic [SumW-1:0]        shifted;
  logic [OUT_W-1:0]       pow_d;

  logic                   s3_valid_q;
  logic [OUT_W-1:0]       s3_data_q;
  half_bin_t              s3_bin_q;

  // Whole pipeline moves together; it only holds when S3 is full and blocked.
  assign advance = !s3_valid_q || dout_ready_i;
  assign in_hs   = din_valid_i && advance;
  assign out_hs  = s3_valid_q && dout_ready_i;

  assign din_ready_o = advance;

  // Input bin counter
  always_comb begin
    cnt_d = cnt_q;
    if (in_hs) begin
      cnt_d = cnt_q + fft_bin_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // S1: capture components; upper half-spectrum enters as a bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_bin_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= in_hs && (cnt_q < fft_bin_t'(FFT_HALF));
      s1_re_q    <= din_data_i[IN_W-1:0];
      s1_im_q    <= din_data_i[2*IN_W-1:IN_W];
      s1_bin_q   <= cnt_q[8:0];
    end
  end

  // S2: squares
  cmag_sq #(
    .IN_W(IN_W)
  ) u_cmag_sq (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (advance),
    .valid_i(s1_valid_q),
    .bin_i  (s1_bin_q),
    .re_i   (s1_re_q),
    .im_i   (s1_im_q),
    .valid_o(s2_valid),
    .bin_o  (s2_bin),
    .sum_o  (s2_sum)
  );

  // Scale and saturate into S3.
  always_comb begin
    shifted = s2_sum >> SHIFT;
    if (|(shifted >> OUT_W)) begin
      pow_d = '1;
    end else begin
      pow_d = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_bin_q   <= '0;
    end else if (advance) begin
      s3_valid_q <= s2_valid;
      s3_data_q  <= pow_d;
      s3_bin_q   <= s2_bin;
    end
  end

  assign dout_valid_o = s3_valid_q;
  assign dout_data_o  = s3_data_q;
  assign dout_bin_o   = s3_bin_q;

`ifdef FFT_POWER_PEAK_EN
  half_bin_t        max_bin_q, cand_bin;
  logic [OUT_W-1:0] max_pow_q, cand_pow;
  logic             peak_valid_q;
  half_bin_t        peak_bin_q;
  logic [OUT_W-1:0] peak_pow_q;

  // Bin 0 reseeds each frame; strict '>' keeps the lowest bin on ties.
  always_comb begin
    cand_bin = max_bin_q;
    cand_pow = max_pow_q;
    if ((s3_bin_q == '0) || (s3_data_q > max_pow_q)) begin
      cand_bin = s3_bin_q;
      cand_pow = s3_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_bin_q    <= '0;
      max_pow_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_pow_q   <= '0;
    end else begin
      peak_valid_q <= 1'b0;
      if (out_hs) begin
        max_bin_q <= cand_bin;
        max_pow_q <= cand_pow;
        if (s3_bin_q == LastBin) begin
          peak_bin_q   <= cand_bin;
          peak_pow_q   <= cand_pow;
          peak_valid_q <= 1'b1;
        end
      end
    end
  end

  assign peak_valid_o = peak_valid_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_pow_o   = peak_pow_q;
`endif

endmodule

// File: tb/tb_fft_power.sv
module tb_fft_power;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din_valid;
  logic [47:0] din_data;
  logic        din_ready, din_ready14;
  logic        dout_valid, dout_valid14;
  logic        dout_ready;
  logic [31:0] dout_data, dout_data14;
  logic [8:0]  dout_bin, dout_bin14;
`ifdef FFT_POWER_PEAK_EN
  logic        peak_valid, peak_valid14;
  logic [8:0]  peak_bin, peak_bin14;
  logic [31:0] peak_pow, peak_pow14;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  logic signed [23:0] re_a [4096];
  logic signed [23:0] im_a [4096];

  logic [31:0] out_data [$];
  logic [8:0]  out_bin  [$];
  logic [31:0] out14    [$];
  logic [8:0]  pk_bin   [$];
  logic [31:0] pk_pow   [$];
  int          pk_dcyc  [$];
  int          last511;
  int          last_in_cyc;
  int          first_out_cyc;
  bit          seen_first;
  bit          stall_prev = 1'b0;
  logic [31:0] held_d;
  logic [8:0]  held_b;

  fft_power #(.IN_W(24), .OUT_W(32), .SHIFT(16)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .din_data_i  (din_data),
    .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready),
    .dout_data_o (dout_data),
    .dout_bin_o  (dout_bin)
`ifdef FFT_POWER_PEAK_EN
    ,
    .peak_valid_o(peak_valid),
    .peak_bin_o  (peak_bin),
    .peak_pow_o  (peak_pow)
`endif
  );

  fft_power #(.IN_W(24), .OUT_W(32), .SHIFT(14)) u_dut14 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready14),
    .din_data_i  (din_data),
    .dout_valid_o(dout_valid14),
    .dout_ready_i(dout_ready),
    .dout_data_o (dout_data14),
    .dout_bin_o  (dout_bin14)
`ifdef FFT_POWER_PEAK_EN
    ,
    .peak_valid_o(peak_valid14),
    .peak_bin_o  (peak_bin14),
    .peak_pow_o  (peak_pow14)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output collector plus hold-during-stall checking.
  always @(negedge clk) begin
    if (stall_prev) begin
      checks++;
      if (!dout_valid || dout_data !== held_d || dout_bin !== held_b) begin
        errors++;
        $display("FAIL stall_hold: valid=%0b data=%h bin=%0d, required valid=1 data=%h bin=%0d",
                 dout_valid, dout_data, dout_bin, held_d, held_b);
      end
    end
    stall_prev = rst_n && dout_valid && !dout_ready;
    held_d = dout_data;
    held_b = dout_bin;
    if (rst_n && dout_valid && dout_ready) begin
      out_data.push_back(dout_data);
      out_bin.push_back(dout_bin);
      out14.push_back(dout_data14);
      if (dout_bin == 9'd511) last511 = cyc;
      if (!seen_first) begin
        seen_first = 1'b1;
        first_out_cyc = cyc;
      end
    end
`ifdef FFT_POWER_PEAK_EN
    if (rst_n && peak_valid) begin
      pk_bin.push_back(peak_bin);
      pk_pow.push_back(peak_pow);
      pk_dcyc.push_back(cyc - last511);
    end
`endif
  end

  function automatic logic [31:0] pw(input logic signed [23:0] re, input logic signed [23:0] im,
                                     input int sh);
    longint r, i;
    longint unsigned s;
    r = re;
    i = im;
    s = longint'(r * r + i * i);
    s = s >> sh;
    if (s > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return s[31:0];
  endfunction

  task automatic push(input logic [47:0] d);
    bit ok;
    int n;
    din_valid = 1'b1;
    din_data = d;
    n = 0;
    do begin
      @(negedge clk);
      ok = din_ready;
      if (ok) last_in_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: din_ready=0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) push({im_a[k], re_a[k]});
    din_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_data.size() < n && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    out_data.delete();
    out_bin.delete();
    out14.delete();
    pk_bin.delete();
    pk_pow.delete();
    pk_dcyc.delete();
    seen_first = 1'b0;
    for (int k = 0; k < 4096; k++) begin
      re_a[k] = '0;
      im_a[k] = '0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout_data !== 32'd0 || dout_bin !== 9'd0) begin
      errors++;
      $display("FAIL reset_dout: valid=%0b data=%h bin=%0d, required 0/0/0",
               dout_valid, dout_data, dout_bin);
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: din_ready=%0b, required 1", din_ready);
    end
`ifdef FFT_POWER_PEAK_EN
    checks++;
    if (peak_valid !== 1'b0 || peak_bin !== 9'd0 || peak_pow !== 32'd0) begin
      errors++;
      $display("FAIL reset_peak: valid=%0b bin=%0d pow=%h, required 0/0/0",
               peak_valid, peak_bin, peak_pow);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%0b ready=%0b, required 0/1", dout_valid, din_ready);
    end
  endtask

  task automatic test_impulse();
    int t0;
    logic [31:0] exp_d;
    clear_all();
    re_a[5] = 24'sd1000;
    push({im_a[0], re_a[0]});
    t0 = last_in_cyc;
    send_range(1, 1023);
    wait_out(512);
    checks++;
    if (first_out_cyc - t0 !== 3) begin
      errors++;
      $display("FAIL latency: %0d cycles, required 3", first_out_cyc - t0);
    end
    checks++;
    if (out_data.size() !== 512) begin
      errors++;
      $display("FAIL impulse_count: %0d outputs, required 512", out_data.size());
    end
    for (int k = 0; k < 512 && k < out_data.size(); k++) begin
      exp_d = (k == 5) ? 32'd15 : 32'd0;
      checks++;
      if (out_data[k] !== exp_d || out_bin[k] !== 9'(k)) begin
        errors++;
        $display("FAIL impulse_bin%0d: data=%0d bin=%0d, required data=%0d bin=%0d",
                 k, out_data[k], out_bin[k], exp_d, k);
      end
    end
`ifdef FFT_POWER_PEAK_EN
    checks++;
    if (pk_bin.size() !== 1 || pk_bin[0] !== 9'd5 || pk_pow[0] !== 32'd15) begin
      errors++;
      $display("FAIL impulse_peak: n=%0d bin=%0d pow=%0d, required n=1 bin=5 pow=15",
               pk_bin.size(), pk_bin[0], pk_pow[0]);
    end
`endif
  endtask

  task automatic test_full_scale();
    logic [31:0] e16 [4];
    logic [31:0] e14 [4];
    clear_all();
    re_a[0] = -24'sd8388608;  im_a[0] = -24'sd8388608;
    re_a[1] = -24'sd8388608;
    re_a[2] = 24'sd8388607;   im_a[2] = -24'sd8388608;
    re_a[3] = 24'sd8388607;
    e16[0] = 32'h8000_0000;  e14[0] = 32'hFFFF_FFFF;
    e16[1] = 32'h4000_0000;  e14[1] = 32'hFFFF_FFFF;
    e16[2] = 32'h7FFF_FF00;  e14[2] = 32'hFFFF_FFFF;
    e16[3] = 32'h3FFF_FF00;  e14[3] = 32'hFFFF_FC00;
    send_range(0, 1023);
    wait_out(512);
    checks++;
    if (out_data.size() !== 512) begin
      errors++;
      $display("FAIL fullscale_count: %0d outputs, required 512", out_data.size());
    end
    for (int k = 0; k < 4 && k < out_data.size(); k++) begin
      checks++;
      if (out_data[k] !== e16[k] || out14[k] !== e14[k]) begin
        errors++;
        $display("FAIL fullscale_bin%0d: s16=%h s14=%h, required s16=%h s14=%h",
                 k, out_data[k], out14[k], e16[k], e14[k]);
      end
    end
`ifdef FFT_POWER_PEAK_EN
    checks++;
    if (pk_bin.size() !== 1 || pk_bin[0] !== 9'd0 || pk_pow[0] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL fullscale_peak: n=%0d bin=%0d pow=%h, required n=1 bin=0 pow=80000000",
               pk_bin.size(), pk_bin[0], pk_pow[0]);
    end
`endif
  endtask

  task automatic test_random_ready();
    logic [31:0] exp_d, mx;
    int mb, idx;
    clear_all();
    for (int k = 0; k < 4096; k++) begin
      re_a[k] = 24'($urandom);
      im_a[k] = 24'($urandom);
    end
    rand_ready = 1'b1;
    send_range(0, 4095);
    wait_out(2048);
    rand_ready = 1'b0;
    checks++;
    if (out_data.size() !== 2048) begin
      errors++;
      $display("FAIL random_count: %0d outputs, required 2048", out_data.size());
    end
    for (int f = 0; f < 4; f++) begin
      mx = 0;
      mb = 0;
      for (int k = 0; k < 512; k++) begin
        idx = f * 512 + k;
        exp_d = pw(re_a[f * 1024 + k], im_a[f * 1024 + k], 16);
        if (k == 0 || exp_d > mx) begin
          mx = exp_d;
          mb = k;
        end
        if (idx < out_data.size()) begin
          checks++;
          if (out_data[idx] !== exp_d || out_bin[idx] !== 9'(k)) begin
            errors++;
            $display("FAIL random_f%0d_bin%0d: data=%h bin=%0d, required data=%h bin=%0d",
                     f, k, out_data[idx], out_bin[idx], exp_d, k);
          end
        end
      end
`ifdef FFT_POWER_PEAK_EN
      checks++;
      if (f >= pk_bin.size() || pk_bin[f] !== 9'(mb) || pk_pow[f] !== mx || pk_dcyc[f] !== 1) begin
        errors++;
        $display("FAIL random_peak_f%0d: n=%0d bin=%0d pow=%h dcyc=%0d, required bin=%0d pow=%h dcyc=1",
                 f, pk_bin.size(), pk_bin[f], pk_pow[f], pk_dcyc[f], mb, mx);
      end
`endif
    end
  endtask

  task automatic test_peak_tie();
    clear_all();
    re_a[3] = 24'sd100;
    re_a[10] = 24'sd500;  im_a[10] = -24'sd300;
    re_a[15] = 24'sd400;  im_a[15] = 24'sd300;
    re_a[20] = 24'sd500;  im_a[20] = -24'sd300;
    send_range(0, 1023);
    wait_out(512);
    checks++;
    if (out_data.size() !== 512 || out_data[10] !== 32'd5 || out_data[15] !== 32'd3
        || out_data[20] !== 32'd5) begin
      errors++;
      $display("FAIL tie_data: n=%0d b10=%0d b15=%0d b20=%0d, required n=512 5/3/5",
               out_data.size(), out_data[10], out_data[15], out_data[20]);
    end
`ifdef FFT_POWER_PEAK_EN
    checks++;
    if (pk_bin.size() !== 1 || pk_bin[0] !== 9'd10 || pk_pow[0] !== 32'd5 || pk_dcyc[0] !== 1) begin
      errors++;
      $display("FAIL tie_peak: n=%0d bin=%0d pow=%0d dcyc=%0d, required n=1 bin=10 pow=5 dcyc=1",
               pk_bin.size(), pk_bin[0], pk_pow[0], pk_dcyc[0]);
    end
`endif
  endtask

  task automatic test_high_bins_dropped();
    logic [31:0] exp_d;
    clear_all();
    re_a[9] = 24'sd300;
    for (int k = 512; k < 1024; k++) begin
      re_a[k] = -24'sd8388608;
      im_a[k] = -24'sd8388608;
    end
    send_range(0, 1023);
    wait_out(512);
    checks++;
    if (out_data.size() !== 512) begin
      errors++;
      $display("FAIL high_count: %0d outputs, required 512", out_data.size());
    end
    for (int k = 0; k < 512 && k < out_data.size(); k++) begin
      exp_d = (k == 9) ? 32'd1 : 32'd0;
      checks++;
      if (out_data[k] !== exp_d || out_bin[k] !== 9'(k)) begin
        errors++;
        $display("FAIL high_bin%0d: data=%h bin=%0d, required data=%h bin=%0d",
                 k, out_data[k], out_bin[k], exp_d, k);
      end
    end
`ifdef FFT_POWER_PEAK_EN
    checks++;
    if (pk_bin.size() !== 1 || pk_bin[0] !== 9'd9 || pk_pow[0] !== 32'd1) begin
      errors++;
      $display("FAIL high_peak: n=%0d bin=%0d pow=%h, required n=1 bin=9 pow=1",
               pk_bin.size(), pk_bin[0], pk_pow[0]);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    clear_all();
    re_a[100] = 24'sd30000;
    send_range(0, 299);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: valid=%0b ready=%0b, required 0/1", dout_valid, din_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_all();
    re_a[7] = 24'sd2000;
    send_range(0, 1023);
    wait_out(512);
    checks++;
    if (out_data.size() !== 512 || out_bin[0] !== 9'd0) begin
      errors++;
      $display("FAIL midreset_restart: n=%0d first_bin=%0d, required n=512 first_bin=0",
               out_data.size(), out_bin[0]);
    end
    checks++;
    if (out_data[7] !== 32'd61 || out_data[100] !== 32'd0) begin
      errors++;
      $display("FAIL midreset_data: b7=%0d b100=%0d, required 61/0", out_data[7], out_data[100]);
    end
`ifdef FFT_POWER_PEAK_EN
    checks++;
    if (pk_bin.size() !== 1 || pk_bin[0] !== 9'd7 || pk_pow[0] !== 32'd61) begin
      errors++;
      $display("FAIL midreset_peak: n=%0d bin=%0d pow=%0d, required n=1 bin=7 pow=61",
               pk_bin.size(), pk_bin[0], pk_pow[0]);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    din_valid = 1'b0;
    din_data = '0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_impulse();
    test_full_scale();
    test_random_ready();
    test_peak_tie();
    test_high_bins_dropped();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
